// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, requester indices and
// the sideband TX arbiter state encoding.
package mbinit_pkg;

  localparam logic [3:0] MSG_START_REQ          = 4'd1;
  localparam logic [3:0] MSG_START_RESP         = 4'd2;
  localparam logic [3:0] MSG_END_REQ            = 4'd3;
  localparam logic [3:0] MSG_END_RESP           = 4'd4;
  localparam logic [3:0] MSG_APPLY_DEGRADE_REQ  = 4'd5;
  localparam logic [3:0] MSG_APPLY_DEGRADE_RESP = 4'd6;

  localparam int REQ_PARAM      = 0;
  localparam int REQ_CAL        = 1;
  localparam int REQ_REPAIRCLK  = 2;
  localparam int REQ_REPAIRVAL  = 3;
  localparam int REQ_REVERSALMB = 4;
  localparam int REQ_REPAIRMB   = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sb_arb_state_t;

endpackage

// File: rtl/mbinit_sb_tx_arbiter_if.sv
// Handshake between the sideband TX arbiter (master) and the packetiser (slave).
interface mbinit_sb_tx_arbiter_if #(
  parameter int MSG_W  = 4,
  parameter int INFO_W = 3,
  parameter int ID_W   = 3
) ();

  logic              o_sb_tx_valid;
  logic [MSG_W-1:0]  o_sb_tx_msg;
  logic [INFO_W-1:0] o_sb_tx_info;
  logic [ID_W-1:0]   o_sb_tx_src;
  logic              i_sb_tx_ack;
  logic              i_sb_tx_done;

  modport master (
    output o_sb_tx_valid, o_sb_tx_msg, o_sb_tx_info, o_sb_tx_src,
    input  i_sb_tx_ack, i_sb_tx_done
  );

  modport slave (
    input  o_sb_tx_valid, o_sb_tx_msg, o_sb_tx_info, o_sb_tx_src,
    output i_sb_tx_ack, i_sb_tx_done
  );

endinterface

// File: rtl/mbinit_rr_picker.sv
// Round-robin winner search: first set pending bit at or above rr_ptr, wrapping.
module mbinit_rr_picker #(
  parameter int NUM_REQ = 6,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_found
);

  always_comb begin
    int idx;
    o_found  = 1'b0;
    o_winner = '0;
    idx      = 0;
    // Walk offsets high to low so the smallest offset from rr_ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(i_rr_ptr) + i) % NUM_REQ;
      if (i_pending[ID_W'(idx)]) begin
        o_found  = 1'b1;
        o_winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Serialises one-cycle message pulses from the MBINIT substate controllers onto
// the single sideband TX path, round-robin, one message in flight at a time.
//   state        | meaning
//   ST_IDLE      | channel free, picking next pending requester
//   ST_SEND      | message presented, waiting for packetiser ack
//   ST_WAIT_DONE | accepted, waiting for serialisation done
module mbinit_sb_tx_arbiter #(
  parameter int NUM_REQ        = 6,
  parameter int MSG_W          = 4,
  parameter int INFO_W         = 3,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*MSG_W-1:0]  i_req_msg,
  input  logic [NUM_REQ*INFO_W-1:0] i_req_info,
  input  logic                      i_flush,
  mbinit_sb_tx_arbiter_if.master    sb_tx,
  output logic                      o_busy,
  output logic                      o_falling_edge_busy,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_drop_err,
  output logic                      o_timeout
);
  import mbinit_pkg::*;

  localparam int              ID_W     = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam int              TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int              TMR_LD_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMR_LD_I);

  sb_arb_state_t     r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [MSG_W-1:0]  r_hold_msg  [NUM_REQ];
  logic [INFO_W-1:0] r_hold_info [NUM_REQ];
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_src;
  logic [TMR_W-1:0]  r_timer;
  logic              r_valid;
  logic [MSG_W-1:0]  r_msg;
  logic [INFO_W-1:0] r_info;
  logic              r_busy;
  logic              r_busy_prev;
  logic              r_feb;
  logic [NUM_REQ-1:0] r_grant;
  logic              r_drop_err;
  logic              r_timeout;

  logic [ID_W-1:0]    w_winner;
  logic               w_found;
  logic               w_start;
  logic               w_complete;
  logic               w_abandon;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_src_onehot;
  logic [ID_W-1:0]    w_ptr_after_src;

  mbinit_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_found   (w_found)
  );

  assign w_start    = (r_state == ST_IDLE) && w_found && !i_flush;
  assign w_clr      = w_start ? (NUM_REQ'(1) << w_winner) : '0;
  // Ack and done together in SEND complete directly.
  assign w_complete = ((r_state == ST_WAIT_DONE) && sb_tx.i_sb_tx_done) ||
                      ((r_state == ST_SEND) && sb_tx.i_sb_tx_ack && sb_tx.i_sb_tx_done);
  assign w_abandon  = (TIMEOUT_CYCLES != 0) && (r_state != ST_IDLE) &&
                      (r_timer == '0) && !w_complete;
  assign w_src_onehot    = NUM_REQ'(1) << r_src;
  assign w_ptr_after_src = (r_src == LAST_ID) ? '0 : r_src + 1'b1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_drop_err <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_hold_msg[k]  <= '0;
        r_hold_info[k] <= '0;
      end
    end else begin
      r_drop_err <= !i_flush && |(i_req_valid & r_pending & ~w_clr);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (i_flush) begin
          r_pending[k] <= 1'b0;
        end else if (i_req_valid[k]) begin
          r_pending[k] <= 1'b1;
          if (!r_pending[k] || w_clr[k]) begin
            r_hold_msg[k]  <= i_req_msg[k*MSG_W +: MSG_W];
            r_hold_info[k] <= i_req_info[k*INFO_W +: INFO_W];
          end
        end else if (w_clr[k]) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_msg       <= '0;
      r_info      <= '0;
      r_src       <= '0;
      r_rr_ptr    <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_busy_prev <= 1'b0;
      r_feb       <= 1'b0;
      r_grant     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_grant     <= '0;
      r_timeout   <= 1'b0;
      r_busy_prev <= r_busy;
      r_feb       <= r_busy_prev & ~r_busy;
      if (r_timer != '0) r_timer <= r_timer - 1'b1;

      if (i_flush) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_complete || w_abandon) begin
        r_state   <= ST_IDLE;
        r_valid   <= 1'b0;
        r_busy    <= 1'b0;
        r_rr_ptr  <= w_ptr_after_src;
        r_grant   <= w_complete ? w_src_onehot : '0;
        r_timeout <= w_abandon;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_found) begin
              r_state <= ST_SEND;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_msg   <= r_hold_msg[w_winner];
              r_info  <= r_hold_info[w_winner];
              r_src   <= w_winner;
              r_timer <= TMR_LOAD;
            end
          end
          ST_SEND: begin
            if (sb_tx.i_sb_tx_ack) begin
              r_state <= ST_WAIT_DONE;
              r_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sb_tx.o_sb_tx_valid = r_valid;
  assign sb_tx.o_sb_tx_msg   = r_msg;
  assign sb_tx.o_sb_tx_info  = r_info;
  assign sb_tx.o_sb_tx_src   = r_src;
  assign o_busy              = r_busy;
  assign o_falling_edge_busy = r_feb;
  assign o_grant             = r_grant;
  assign o_drop_err          = r_drop_err;
  assign o_timeout           = r_timeout;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Directed and randomized checks of the MBINIT sideband TX arbiter against a
// queue-free round-robin reference model.
module tb_mbinit_sb_tx_arbiter;
  import mbinit_pkg::*;

  localparam int NUM_REQ = 6;
  localparam int MSG_W   = 4;
  localparam int INFO_W  = 3;
  localparam int ID_W    = 3;
  localparam int TMO     = 16;

  logic                      CLK = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*MSG_W-1:0]  req_msg;
  logic [NUM_REQ*INFO_W-1:0] req_info;
  logic                      flush;
  logic                      busy, feb, drop_err, timeout;
  logic [NUM_REQ-1:0]        grant;

  int checks = 0;
  int errors = 0;

  int m_ptr;
  bit m_pend [NUM_REQ];
  int m_msg  [NUM_REQ];
  int m_info [NUM_REQ];

  mbinit_sb_tx_arbiter_if #(.MSG_W(MSG_W), .INFO_W(INFO_W), .ID_W(ID_W)) sb_if ();

  mbinit_sb_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .INFO_W(INFO_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .i_req_valid         (req_valid),
    .i_req_msg           (req_msg),
    .i_req_info          (req_info),
    .i_flush             (flush),
    .sb_tx               (sb_if.master),
    .o_busy              (busy),
    .o_falling_edge_busy (feb),
    .o_grant             (grant),
    .o_drop_err          (drop_err),
    .o_timeout           (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int k, input int msg, input int info);
    req_valid[k] = 1'b1;
    req_msg[k*MSG_W +: MSG_W]    = 4'(msg);
    req_info[k*INFO_W +: INFO_W] = 3'(info);
  endtask

  function automatic int m_pick();
    for (int i = 0; i < NUM_REQ; i++)
      if (m_pend[(m_ptr + i) % NUM_REQ]) return (m_ptr + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic bit m_any();
    return m_pick() >= 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, sb_if.o_sb_tx_valid, 0);
    chk({tag, "_msg"},   sb_if.o_sb_tx_msg, 0);
    chk({tag, "_info"},  sb_if.o_sb_tx_info, 0);
    chk({tag, "_src"},   sb_if.o_sb_tx_src, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_feb"},   feb, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_drop"},  drop_err, 0);
    chk({tag, "_tmo"},   timeout, 0);
  endtask

  task automatic wait_valid_chk(input string tag, input int src, input int msg, input int info);
    int n;
    n = 0;
    while (sb_if.o_sb_tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, sb_if.o_sb_tx_valid, 1);
    chk({tag, "_src"},   sb_if.o_sb_tx_src, src);
    chk({tag, "_msg"},   sb_if.o_sb_tx_msg, msg);
    chk({tag, "_info"},  sb_if.o_sb_tx_info, info);
    chk({tag, "_busy"},  busy, 1);
  endtask

  task automatic do_ack(input int dly, input bit with_done);
    repeat (dly) step();
    sb_if.i_sb_tx_ack  = 1'b1;
    sb_if.i_sb_tx_done = with_done;
    step();
    sb_if.i_sb_tx_ack  = 1'b0;
    sb_if.i_sb_tx_done = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int src, input int waits,
                             input bit more, input bit done_given);
    if (!done_given) begin
      chk({tag, "_ackdrop"}, sb_if.o_sb_tx_valid, 0);
      repeat (waits) step();
      sb_if.i_sb_tx_done = 1'b1;
      step();
      sb_if.i_sb_tx_done = 1'b0;
    end
    chk({tag, "_grant"}, grant, 1 << src);
    chk({tag, "_busy0"}, busy, 0);
    m_ptr = (src + 1) % NUM_REQ;
    step();
    chk({tag, "_grant0"}, grant, 0);
    chk({tag, "_feb"},    feb, 1);
    chk({tag, "_next"},   sb_if.o_sb_tx_valid, more);
    chk({tag, "_nbusy"},  busy, more);
  endtask

  initial begin
    int mask, mb, w, ackd, mg, inf;
    bit exp_drop, first;

    req_valid = '0; req_msg = '0; req_info = '0; flush = 1'b0;
    sb_if.i_sb_tx_ack = 1'b0; sb_if.i_sb_tx_done = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < NUM_REQ; k++) begin m_pend[k] = 0; m_msg[k] = 0; m_info[k] = 0; end

    #2;
    chk_all_zero("rst");
    @(posedge CLK); @(posedge CLK); #3 rst_n = 1'b1;
    step();

    // single request from REPAIRMB: valid at t2, ack t4, done t7
    pulse(REQ_REPAIRMB, MSG_START_REQ, 3);
    step(); req_valid = '0;
    chk("t1_v_t1", sb_if.o_sb_tx_valid, 0);
    step();
    chk("t1_v_t2", sb_if.o_sb_tx_valid, 1);
    wait_valid_chk("t1", REQ_REPAIRMB, 1, 3);
    do_ack(2, 0);
    finish_xfer("t1", REQ_REPAIRMB, 2, 0, 0);

    // move rr_ptr to 2, then 1 and 4 together -> 4 first
    pulse(REQ_CAL, MSG_END_REQ, 1);
    step(); req_valid = '0;
    wait_valid_chk("t2a", REQ_CAL, 3, 1);
    do_ack(0, 1);
    finish_xfer("t2a", REQ_CAL, 0, 0, 1);
    pulse(REQ_CAL, MSG_END_RESP, 6);
    pulse(REQ_REVERSALMB, MSG_START_RESP, 2);
    step(); req_valid = '0;
    wait_valid_chk("t2b", REQ_REVERSALMB, 2, 2);
    do_ack(1, 0);
    finish_xfer("t2b", REQ_REVERSALMB, 1, 1, 0);
    wait_valid_chk("t2c", REQ_CAL, 4, 6);
    do_ack(0, 0);
    finish_xfer("t2c", REQ_CAL, 0, 0, 0);

    // duplicate from REPAIRVAL while channel busy
    pulse(REQ_PARAM, MSG_END_REQ, 2);
    step(); req_valid = '0;
    wait_valid_chk("t3a", REQ_PARAM, 3, 2);
    do_ack(0, 0);
    pulse(REQ_REPAIRVAL, MSG_START_RESP, 5);
    step();
    pulse(REQ_REPAIRVAL, MSG_APPLY_DEGRADE_REQ, 1);
    chk("t3_drop_a", drop_err, 0);
    step(); req_valid = '0;
    chk("t3_drop_b", drop_err, 1);
    step();
    chk("t3_drop_c", drop_err, 0);
    finish_xfer("t3a", REQ_PARAM, 0, 1, 1'b0);
    wait_valid_chk("t3b", REQ_REPAIRVAL, 2, 5);
    do_ack(0, 1);
    finish_xfer("t3b", REQ_REPAIRVAL, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_nosend", sb_if.o_sb_tx_valid, 0);
      step();
    end

    // timeout: done withheld, rr_ptr=4 so PARAM first
    pulse(REQ_PARAM, MSG_APPLY_DEGRADE_RESP, 7);
    pulse(REQ_REPAIRCLK, MSG_START_REQ, 0);
    step(); req_valid = '0;
    wait_valid_chk("t4a", REQ_PARAM, 6, 7);
    do_ack(0, 0);
    repeat (TMO - 2) step();
    chk("t4_tmo_early", timeout, 0);
    step();
    chk("t4_tmo", timeout, 1);
    chk("t4_grant", grant, 0);
    chk("t4_valid", sb_if.o_sb_tx_valid, 0);
    chk("t4_busy", busy, 0);
    m_ptr = 1;
    step();
    chk("t4_tmo_pulse", timeout, 0);
    wait_valid_chk("t4b", REQ_REPAIRCLK, 1, 0);
    do_ack(0, 1);
    finish_xfer("t4b", REQ_REPAIRCLK, 0, 0, 1);

    // flush in WAIT_DONE with two pending
    pulse(REQ_REPAIRVAL, MSG_END_RESP, 4);
    step(); req_valid = '0;
    wait_valid_chk("t5", REQ_REPAIRVAL, 4, 4);
    do_ack(0, 0);
    pulse(REQ_CAL, MSG_START_REQ, 1);
    pulse(REQ_REPAIRMB, MSG_END_REQ, 2);
    step(); req_valid = '0;
    flush = 1'b1;
    pulse(REQ_REPAIRCLK, MSG_START_RESP, 3);
    step(); flush = 1'b0; req_valid = '0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", sb_if.o_sb_tx_valid, 0);
    chk("t5_grant", grant, 0);
    chk("t5_drop", drop_err, 0);
    step();
    chk("t5_feb", feb, 1);
    sb_if.i_sb_tx_done = 1'b1;
    step();
    sb_if.i_sb_tx_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_idle_grant", grant, 0);
      chk("t5_idle_valid", sb_if.o_sb_tx_valid, 0);
      step();
    end

    // reset while SEND
    pulse(REQ_REVERSALMB, MSG_START_REQ, 5);
    step(); req_valid = '0;
    wait_valid_chk("t6s", REQ_REVERSALMB, 1, 5);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6r");
    @(posedge CLK); #3 rst_n = 1'b1;
    m_ptr = 0;
    step();
    pulse(REQ_PARAM, MSG_END_RESP, 1);
    pulse(REQ_REPAIRVAL, MSG_END_REQ, 2);
    step(); req_valid = '0;
    wait_valid_chk("t6a", REQ_PARAM, 4, 1);
    do_ack(1, 0);
    finish_xfer("t6a", REQ_PARAM, 1, 1, 0);
    wait_valid_chk("t6b", REQ_REPAIRVAL, 3, 2);
    do_ack(0, 1);
    finish_xfer("t6b", REQ_REPAIRVAL, 0, 0, 1);

    // randomized rounds against the model
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, 63);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (mask[k]) begin
          m_msg[k] = $urandom_range(0, 15);
          m_info[k] = $urandom_range(0, 7);
          m_pend[k] = 1;
          pulse(k, m_msg[k], m_info[k]);
        end
      end
      step(); req_valid = '0;
      first = 1;
      while (m_any()) begin
        w = m_pick();
        m_pend[w] = 0;
        wait_valid_chk("rnd", w, m_msg[w], m_info[w]);
        ackd = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) begin
          do_ack(ackd, 1);
          finish_xfer("rnd_ad", w, 0, m_any(), 1);
        end else begin
          do_ack(ackd, 0);
          if (first && $urandom_range(0, 1) == 1) begin
            mb = $urandom_range(1, 63);
            exp_drop = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
              if (mb[k]) begin
                mg = $urandom_range(0, 15);
                inf = $urandom_range(0, 7);
                if (m_pend[k]) exp_drop = 1;
                else begin
                  m_pend[k] = 1; m_msg[k] = mg; m_info[k] = inf;
                end
                pulse(k, mg, inf);
              end
            end
            step(); req_valid = '0;
            chk("rnd_drop", drop_err, exp_drop);
          end
          finish_xfer("rnd", w, $urandom_range(0, 2), m_any(), 0);
        end
        first = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
